aref_scheduler: RTL and testbench
=================================

AREF_SCHEDULER -- requirements
Module: aref_scheduler

Interface
REQ-001 SHALL have parameter TRP, default 10'd12, giving the idle cycles between PRE-all ack and REF issue.
REQ-002 SHALL have parameter MAX_POSTPONE, default 4'd8, giving the maximum number of owed refreshes (1..15).
REQ-003 SHALL have parameter PRE_ALL_INSTR, default 32'h0, giving the 32-bit DDR_INSTR word for precharge-all.
REQ-004 SHALL have parameter REF_INSTR, default 32'h0, giving the 32-bit DDR_INSTR word for auto-refresh.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port aref_set_interval, input, 1: one-cycle strobe to load the tREFI value.
REQ-008 SHALL have port aref_interval, input, 28: tREFI in clk cycles; 0 disables refresh.
REQ-009 SHALL have port aref_set_trfc, input, 1: one-cycle strobe to load the tRFC value.
REQ-010 SHALL have port aref_trfc, input, 28: tRFC in clk cycles.
REQ-011 SHALL have ports host_en (input, 1), host_instr (input, 32) and host_ack (output, 1): the upstream instruction slot.
REQ-012 SHALL have ports disp_en (output, 1), disp_instr (output, 32) and disp_ack (input, 1): the dispatcher slot-0 side.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port pending, output, 4: refreshes owed.
REQ-015 SHALL have port ref_count, output, 16: REFs issued; wraps at 16'hFFFF.

Function
REQ-016 SHALL hold interval_r and trfc_r (28 b each), loaded on their set strobes; a strobe while busy SHALL NOT disturb the FSM.
REQ-017 SHALL run tick counter tcnt (28 b) as follows:
- interval_r==0: tcnt held at 0, no ticks.
- Otherwise: tcnt decrements each cycle; at tcnt==1 it raises a tick and reloads interval_r.
- aref_set_interval: tcnt loads the new value; pending is kept.
REQ-018 SHALL update pending as follows:
- tick: +1, saturating at MAX_POSTPONE (extra ticks dropped).
- REF handshake: -1.
- Both in the same cycle: pending unchanged.
REQ-019 SHALL implement FSM states IDLE, PRE, WAIT_RP, REF, WAIT_RFC, one-hot or encoded.
REQ-020 In IDLE the block SHALL pass the slot through combinationally: disp_en=host_en, disp_instr=host_instr, host_ack=disp_ack.
REQ-021 IDLE->PRE SHALL occur at the clock edge when pending!=0 and (host_en==0 or pending==MAX_POSTPONE); the host handshake in that cycle SHALL complete normally.
REQ-022 Outside IDLE, host_ack SHALL be 0; disp_en and disp_instr SHALL be driven only by the FSM; host_instr SHALL be ignored.
REQ-023 PRE SHALL drive disp_en=1 and disp_instr=PRE_ALL_INSTR until disp_ack; then load wcnt=TRP and go to WAIT_RP.
REQ-024 WAIT_RP SHALL drive disp_en=0 and decrement wcnt; at wcnt<=1 it SHALL go to REF. TRP==0 SHALL behave as 1.
REQ-025 REF SHALL drive disp_en=1 and disp_instr=REF_INSTR until disp_ack. On ack it SHALL:
- increment ref_count;
- decrement pending;
- load wcnt=trfc_r (0 treated as 1);
- go to WAIT_RFC.
REQ-026 WAIT_RFC SHALL drive disp_en=0 and count down; at wcnt<=1 it SHALL go to REF if pending!=0 (banks still closed, no PRE), else to IDLE.
REQ-027 SHALL NOT produce combinational paths from disp_ack to disp_en or disp_instr outside IDLE.
REQ-028 disp_instr SHALL be 32'h0 when disp_en==0 outside IDLE.
REQ-029 A tick arriving during PRE through WAIT_RFC SHALL increment pending and be serviced by the REQ-026 REF loop.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL set:
- state to IDLE;
- interval_r, trfc_r, tcnt and wcnt to 0;
- pending to 0;
- ref_count to 0.
REQ-031 After reset, outputs SHALL be busy=0, pending=0 and ref_count=0, with passthrough active from the first cycle.
REQ-032 Reset mid-sequence SHALL abandon any unacked PRE or REF with no completion.

Verification
REQ-033 Load interval=100 and trfc=20, TRP=12, host idle -> tick at cycle 100; then PRE, ack, 12 idle cycles, REF, ack, 20 idle cycles, IDLE; ref_count=1, pending=0.
REQ-034 Host streams back-to-back instructions with interval=50 -> pending rises to 8 by cycle 400; the next cycle forces PRE, host_ack=0 until 8 REFs complete, ref_count=8.
REQ-035 Tick coincides with REF ack (pending=2) -> pending stays 2.
REQ-036 interval=0 for 10000 cycles -> no PRE or REF, busy=0.
REQ-037 rst asserted in WAIT_RFC with pending=3 -> next cycle state IDLE, pending=0, host_ack follows disp_ack.
REQ-038 aref_set_interval with 200 at tcnt=5 -> no tick until 200 cycles later.

Source files
------------

// File: rtl/aref_scheduler.sv
// Auto-refresh scheduler: counts tREFI ticks into a bounded owed-refresh
// counter and, when allowed, takes over the dispatcher slot to issue
// PRE-all followed by one or more back-to-back REF commands.
`timescale 1ns/1ps
module aref_scheduler #(
    parameter logic [9:0]  TRP           = 10'd12,
    parameter logic [3:0]  MAX_POSTPONE  = 4'd8,
    parameter logic [31:0] PRE_ALL_INSTR = 32'h0,
    parameter logic [31:0] REF_INSTR     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aref_set_interval,
    input  logic [27:0] aref_interval,
    input  logic        aref_set_trfc,
    input  logic [27:0] aref_trfc,
    input  logic        host_en,
    input  logic [31:0] host_instr,
    output logic        host_ack,
    output logic        disp_en,
    output logic [31:0] disp_instr,
    input  logic        disp_ack,
    output logic        busy,
    output logic [3:0]  pending,
    output logic [15:0] ref_count
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRE      = 3'd1;
    localparam logic [2:0] ST_WAIT_RP  = 3'd2;
    localparam logic [2:0] ST_REF      = 3'd3;
    localparam logic [2:0] ST_WAIT_RFC = 3'd4;

    // A zero precharge wait still needs one idle cycle before REF.
    localparam logic [27:0] TRP_LOAD = (TRP == 10'd0) ? 28'd1 : {18'd0, TRP};

    logic [2:0]  state_q,     state_d;
    logic [27:0] interval_q,  interval_d;
    logic [27:0] trfc_q,      trfc_d;
    logic [27:0] tcnt_q,      tcnt_d;
    logic [27:0] wcnt_q,      wcnt_d;
    logic [3:0]  pending_q,   pending_d;
    logic [15:0] ref_count_q, ref_count_d;

    logic tick;
    logic ref_done;

    assign tick     = (interval_q != 28'd0) && (tcnt_q == 28'd1);
    assign ref_done = (state_q == ST_REF) && disp_ack;

    assign busy      = (state_q != ST_IDLE);
    assign pending   = pending_q;
    assign ref_count = ref_count_q;

    // Configuration registers and the free-running tREFI tick counter.
    always_comb begin
        interval_d = interval_q;
        trfc_d     = trfc_q;
        tcnt_d     = tcnt_q;
        if (aref_set_interval) begin
            interval_d = aref_interval;
        end
        if (aref_set_trfc) begin
            trfc_d = aref_trfc;
        end
        if (aref_set_interval) begin
            tcnt_d = aref_interval;
        end else if (interval_q == 28'd0) begin
            tcnt_d = 28'd0;
        end else if (tcnt_q <= 28'd1) begin
            tcnt_d = interval_q;
        end else begin
            tcnt_d = tcnt_q - 28'd1;
        end
    end

    // Owed-refresh bookkeeping: a tick and a REF ack in one cycle cancel.
    always_comb begin
        pending_d   = pending_q;
        ref_count_d = ref_count_q;
        if (ref_done) begin
            ref_count_d = ref_count_q + 16'd1;
        end
        if (tick && ref_done) begin
            pending_d = pending_q;
        end else if (tick && (pending_q != MAX_POSTPONE)) begin
            pending_d = pending_q + 4'd1;
        end else if (ref_done && (pending_q != 4'd0)) begin
            pending_d = pending_q - 4'd1;
        end
    end

    // Refresh FSM and slot ownership; outside IDLE the slot outputs depend on state only.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        disp_en    = 1'b0;
        disp_instr = 32'h0;
        host_ack   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                disp_en    = host_en;
                disp_instr = host_instr;
                host_ack   = disp_ack;
                if ((pending_q != 4'd0) && (!host_en || (pending_q == MAX_POSTPONE))) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                disp_en    = 1'b1;
                disp_instr = PRE_ALL_INSTR;
                if (disp_ack) begin
                    wcnt_d  = TRP_LOAD;
                    state_d = ST_WAIT_RP;
                end
            end
            ST_WAIT_RP: begin
                if (wcnt_q != 28'd0) begin
                    wcnt_d = wcnt_q - 28'd1;
                end
                if (wcnt_q <= 28'd1) begin
                    state_d = ST_REF;
                end
            end
            ST_REF: begin
                disp_en    = 1'b1;
                disp_instr = REF_INSTR;
                if (disp_ack) begin
                    wcnt_d  = (trfc_q == 28'd0) ? 28'd1 : trfc_q;
                    state_d = ST_WAIT_RFC;
                end
            end
            ST_WAIT_RFC: begin
                if (wcnt_q != 28'd0) begin
                    wcnt_d = wcnt_q - 28'd1;
                end
                // Banks are still closed after a REF, so owed refreshes skip PRE.
                if (wcnt_q <= 28'd1) begin
                    state_d = (pending_q != 4'd0) ? ST_REF : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            interval_q  <= 28'd0;
            trfc_q      <= 28'd0;
            tcnt_q      <= 28'd0;
            wcnt_q      <= 28'd0;
            pending_q   <= 4'd0;
            ref_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            trfc_q      <= trfc_d;
            tcnt_q      <= tcnt_d;
            wcnt_q      <= wcnt_d;
            pending_q   <= pending_d;
            ref_count_q <= ref_count_d;
        end
    end

endmodule

// File: tb/tb_aref_scheduler.sv
// Directed bench for aref_scheduler: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_aref_scheduler;

    localparam logic [31:0] PRE_I = 32'hA000_0001;
    localparam logic [31:0] REF_I = 32'hB000_0002;

    logic        clk = 1'b0;
    logic        rst;
    logic        aref_set_interval;
    logic [27:0] aref_interval;
    logic        aref_set_trfc;
    logic [27:0] aref_trfc;
    logic        host_en;
    logic [31:0] host_instr;
    logic        host_ack;
    logic        disp_en;
    logic [31:0] disp_instr;
    logic        disp_ack;
    logic        busy;
    logic [3:0]  pending;
    logic [15:0] ref_count;

    logic auto_ack;
    logic man_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Dispatcher model: either acks whatever is presented, or is driven by hand.
    assign disp_ack = auto_ack ? disp_en : man_ack;

    always #5 clk = ~clk;

    aref_scheduler #(
        .TRP           (10'd12),
        .MAX_POSTPONE  (4'd8),
        .PRE_ALL_INSTR (PRE_I),
        .REF_INSTR     (REF_I)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .aref_set_interval (aref_set_interval),
        .aref_interval     (aref_interval),
        .aref_set_trfc     (aref_set_trfc),
        .aref_trfc         (aref_trfc),
        .host_en           (host_en),
        .host_instr        (host_instr),
        .host_ack          (host_ack),
        .disp_en           (disp_en),
        .disp_instr        (disp_instr),
        .disp_ack          (disp_ack),
        .busy              (busy),
        .pending           (pending),
        .ref_count         (ref_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        aref_set_interval = 1'b0;
        aref_interval = 28'd0;
        aref_set_trfc = 1'b0;
        aref_trfc = 28'd0;
        host_en = 1'b0;
        host_instr = 32'h0;
        auto_ack = 1'b0;
        man_ack = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic load(input logic [27:0] iv, input logic [27:0] tr);
        aref_set_interval = 1'b1;
        aref_interval = iv;
        aref_set_trfc = 1'b1;
        aref_trfc = tr;
        step();
        aref_set_interval = 1'b0;
        aref_set_trfc = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_checks++; if (ref_count !== 16'd0) begin n_fail++; $display("FAIL reset_ref_count: got %0d want 0", ref_count); end
        host_en = 1'b1; host_instr = 32'h1234_5678; man_ack = 1'b1; #1;
        n_checks++; if (disp_en !== 1'b1) begin n_fail++; $display("FAIL pass_en: got %0b want 1", disp_en); end
        n_checks++; if (disp_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL pass_instr: got %h want 12345678", disp_instr); end
        n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL pass_ack1: got %0b want 1", host_ack); end
        man_ack = 1'b0; #1;
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL pass_ack0: got %0b want 0", host_ack); end
        host_en = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_single_refresh();
        int n;
        do_reset();
        load(28'd100, 28'd20);
        repeat (99) step();
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL sr_pre_tick: pending %0d want 0", pending); end
        step();
        n_checks++; if (pending !== 4'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL sr_tick: pending %0d busy %0b want 1/0", pending, busy); end
        step();
        n_checks++; if (busy !== 1'b1 || disp_en !== 1'b1 || disp_instr !== PRE_I) begin n_fail++; $display("FAIL sr_pre: busy %0b en %0b instr %h want 1/1/%h", busy, disp_en, disp_instr, PRE_I); end
        host_en = 1'b1; host_instr = 32'hDEAD_BEEF;
        step();
        n_checks++; if (disp_instr !== PRE_I) begin n_fail++; $display("FAIL sr_pre_hold: instr %h want %h", disp_instr, PRE_I); end
        man_ack = 1'b1; #1;
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL sr_host_ack_blocked: got %0b want 0", host_ack); end
        step();
        man_ack = 1'b0;
        n_checks++; if (busy !== 1'b1 || disp_en !== 1'b0 || disp_instr !== 32'h0) begin n_fail++; $display("FAIL sr_wait_rp: busy %0b en %0b instr %h want 1/0/0", busy, disp_en, disp_instr); end
        n = 0;
        while (busy && !disp_en && n < 100) begin n++; step(); end
        n_checks++; if (n !== 12) begin n_fail++; $display("FAIL sr_trp_len: got %0d want 12", n); end
        n_checks++; if (disp_en !== 1'b1 || disp_instr !== REF_I) begin n_fail++; $display("FAIL sr_ref: en %0b instr %h want 1/%h", disp_en, disp_instr, REF_I); end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++; if (ref_count !== 16'd1 || pending !== 4'd0) begin n_fail++; $display("FAIL sr_ref_done: ref_count %0d pending %0d want 1/0", ref_count, pending); end
        n = 0;
        while (busy && !disp_en && n < 100) begin n++; step(); end
        n_checks++; if (n !== 20) begin n_fail++; $display("FAIL sr_trfc_len: got %0d want 20", n); end
        n_checks++; if (busy !== 1'b0 || disp_instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sr_idle: busy %0b instr %h want 0/deadbeef", busy, disp_instr); end
        host_en = 1'b0;
        $display("test_single_refresh: done");
    endtask

    task automatic test_saturation();
        int n;
        int bad;
        do_reset();
        host_en = 1'b1; host_instr = 32'h0000_00C3; auto_ack = 1'b1;
        load(28'd50, 28'd2);
        repeat (350) step();
        n_checks++; if (pending !== 4'd7 || busy !== 1'b0 || host_ack !== 1'b1) begin n_fail++; $display("FAIL sat_p7: pending %0d busy %0b hack %0b want 7/0/1", pending, busy, host_ack); end
        repeat (50) step();
        n_checks++; if (pending !== 4'd8 || busy !== 1'b0) begin n_fail++; $display("FAIL sat_p8: pending %0d busy %0b want 8/0", pending, busy); end
        step();
        n_checks++; if (busy !== 1'b1 || host_ack !== 1'b0 || disp_instr !== PRE_I) begin n_fail++; $display("FAIL sat_force: busy %0b hack %0b instr %h want 1/0/%h", busy, host_ack, disp_instr, PRE_I); end
        n = 0; bad = 0;
        while (busy && n < 300) begin
            if (host_ack !== 1'b0) bad++;
            n++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sat_host_ack: %0d cycles acked, want 0", bad); end
        n_checks++; if (n !== 37) begin n_fail++; $display("FAIL sat_len: busy %0d cycles want 37", n); end
        n_checks++; if (ref_count !== 16'd8 || pending !== 4'd0) begin n_fail++; $display("FAIL sat_done: ref_count %0d pending %0d want 8/0", ref_count, pending); end
        auto_ack = 1'b0; host_en = 1'b0;
        $display("test_saturation: done");
    endtask

    task automatic test_tick_on_ref_ack();
        do_reset();
        host_en = 1'b1;
        load(28'd50, 28'd20);
        repeat (100) step();
        n_checks++; if (pending !== 4'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL tr_p2: pending %0d busy %0b want 2/0", pending, busy); end
        host_en = 1'b0;
        step();
        n_checks++; if (disp_instr !== PRE_I) begin n_fail++; $display("FAIL tr_pre: instr %h want %h", disp_instr, PRE_I); end
        man_ack = 1'b1; step(); man_ack = 1'b0;
        repeat (12) step();
        n_checks++; if (disp_en !== 1'b1 || disp_instr !== REF_I) begin n_fail++; $display("FAIL tr_ref: en %0b instr %h want 1/%h", disp_en, disp_instr, REF_I); end
        repeat (35) step();
        man_ack = 1'b1; step(); man_ack = 1'b0;
        n_checks++; if (pending !== 4'd2) begin n_fail++; $display("FAIL tr_coincide: pending %0d want 2", pending); end
        n_checks++; if (ref_count !== 16'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL tr_count: ref_count %0d busy %0b want 1/1", ref_count, busy); end
        $display("test_tick_on_ref_ack: done");
    endtask

    task automatic test_reset_mid_sequence();
        do_reset();
        host_en = 1'b1;
        load(28'd30, 28'd20);
        repeat (120) step();
        n_checks++; if (pending !== 4'd4) begin n_fail++; $display("FAIL rm_p4: pending %0d want 4", pending); end
        host_en = 1'b0;
        step();
        man_ack = 1'b1; step(); man_ack = 1'b0;
        repeat (12) step();
        man_ack = 1'b1; step(); man_ack = 1'b0;
        step();
        n_checks++; if (pending !== 4'd3 || busy !== 1'b1 || disp_en !== 1'b0) begin n_fail++; $display("FAIL rm_wait_rfc: pending %0d busy %0b en %0b want 3/1/0", pending, busy, disp_en); end
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || pending !== 4'd0 || ref_count !== 16'd0) begin n_fail++; $display("FAIL rm_cleared: busy %0b pending %0d ref_count %0d want 0/0/0", busy, pending, ref_count); end
        host_en = 1'b1; host_instr = 32'h0BAD_F00D; man_ack = 1'b1; #1;
        n_checks++; if (host_ack !== 1'b1 || disp_instr !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rm_pass: hack %0b instr %h want 1/0badf00d", host_ack, disp_instr); end
        man_ack = 1'b0; #1;
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rm_pass0: hack %0b want 0", host_ack); end
        host_en = 1'b0;
        $display("test_reset_mid_sequence: done");
    endtask

    task automatic test_disabled();
        int bad;
        do_reset();
        load(28'd0, 28'd20);
        bad = 0;
        repeat (10000) begin
            if (busy !== 1'b0 || disp_en !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL dis_activity: %0d active cycles want 0", bad); end
        n_checks++; if (pending !== 4'd0 || ref_count !== 16'd0) begin n_fail++; $display("FAIL dis_counts: pending %0d ref_count %0d want 0/0", pending, ref_count); end
        $display("test_disabled: done");
    endtask

    task automatic test_reload();
        do_reset();
        host_en = 1'b1; auto_ack = 1'b1;
        load(28'd30, 28'd20);
        repeat (25) step();
        aref_set_interval = 1'b1; aref_interval = 28'd200;
        step();
        aref_set_interval = 1'b0;
        repeat (4) step();
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rl_old_tick: pending %0d want 0", pending); end
        repeat (195) step();
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rl_early: pending %0d want 0", pending); end
        step();
        n_checks++; if (pending !== 4'd1) begin n_fail++; $display("FAIL rl_tick: pending %0d want 1", pending); end
        auto_ack = 1'b0; host_en = 1'b0;
        $display("test_reload: done");
    endtask

    initial begin
        test_reset();
        test_single_refresh();
        test_saturation();
        test_tick_on_ref_ack();
        test_reset_mid_sequence();
        test_disabled();
        test_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
